rf_op_sequencer: RTL and testbench

//  Multi-cycle controller that sequences the 8-entry register file for one ALU-type instruction at a time.

---
 rtl/rf_op_sequencer.sv | 130 +++++++++++++
 tb/tb_rf_op_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_op_sequencer.sv
// rf_op_sequencer
// Multi-cycle controller that runs one ALU-type instruction at a time against
// an external 8-entry register file: accept, read operands, execute, write back.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   instr_valid/ready   instruction handshake (ready only while idle)
//   instr[11:0]         {opcode[11:9], rd[8:6], rs1[5:3], rs2[2:0]}
//   instr_imm[N-1:0]    immediate for ADDI / LI
//   rf_ra1/ra2          read addresses, driven only in READ
//   rf_rd1/rd2          combinational read data from the register file
//   rf_wa3/wd3/we3      write port, driven only in WB
//   done                one-cycle retire pulse
//   result              last ALU result, held until the next retire
//
// state | meaning
// IDLE  | ready for an instruction; captures it on handshake
// READ  | read addresses out; operands latched at the edge
// EXEC  | ALU result computed into the result register
// WB    | write port driven, done pulses
module rf_op_sequencer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [11:0]  instr,
    input  logic [N-1:0] instr_imm,
    output logic [2:0]   rf_ra1,
    output logic [2:0]   rf_ra2,
    input  logic [N-1:0] rf_rd1,
    input  logic [N-1:0] rf_rd2,
    output logic [2:0]   rf_wa3,
    output logic [N-1:0] rf_wd3,
    output logic         rf_we3,
    output logic         done,
    output logic [N-1:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_ADDI = 3'b101;
    localparam logic [2:0] OP_LI   = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    state_t       state;
    logic [2:0]   opcode;
    logic [2:0]   rd;
    logic [2:0]   rs1;
    logic [2:0]   rs2;
    logic [N-1:0] imm;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic [N-1:0] alu;

    always_comb begin
        alu = '0;
        case (opcode)
            OP_ADD:  alu = op_a + op_b;
            OP_SUB:  alu = op_a - op_b;
            OP_AND:  alu = op_a & op_b;
            OP_OR:   alu = op_a | op_b;
            OP_SLT:  alu = {{(N-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_ADDI: alu = op_a + imm;
            OP_LI:   alu = imm;
            OP_NOP:  alu = '0;
            default: alu = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            opcode <= '0;
            rd     <= '0;
            rs1    <= '0;
            rs2    <= '0;
            imm    <= '0;
            op_a   <= '0;
            op_b   <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        opcode <= instr[11:9];
                        rd     <= instr[8:6];
                        rs1    <= instr[5:3];
                        rs2    <= instr[2:0];
                        imm    <= instr_imm;
                        state  <= READ;
                    end
                end
                READ: begin
                    op_a  <= rf_rd1;
                    op_b  <= rf_rd2;
                    state <= EXEC;
                end
                EXEC: begin
                    result <= alu;
                    state  <= WB;
                end
                WB:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are pure decodes of registered state; rst additionally masks
    // the write and the retire pulse so an aborted WB has no visible effect.
    assign instr_ready = (state == IDLE);
    assign rf_ra1      = (state == READ) ? rs1 : 3'd0;
    assign rf_ra2      = (state == READ) ? rs2 : 3'd0;
    assign rf_wa3      = (state == WB) ? rd : 3'd0;
    assign rf_wd3      = (state == WB) ? result : '0;
    assign rf_we3      = (state == WB) && !rst && (rd != 3'd0) && (opcode != OP_NOP);
    assign done        = (state == WB) && !rst;

endmodule

// File: tb/tb_rf_op_sequencer.sv
module tb_rf_op_sequencer;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [11:0] instr;
    logic [7:0]  instr_imm;
    logic [2:0]  rf_ra1, rf_ra2, rf_wa3;
    logic [7:0]  rf_rd1, rf_rd2, rf_wd3;
    logic        rf_we3;
    logic        done;
    logic [7:0]  result;

    rf_op_sequencer #(.N(8)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_imm(instr_imm),
        .rf_ra1(rf_ra1), .rf_ra2(rf_ra2),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .rf_wa3(rf_wa3), .rf_wd3(rf_wd3), .rf_we3(rf_we3),
        .done(done), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External register file seen by the DUT
    logic [7:0] phys_rf [8] = '{default: 8'h00};
    assign rf_rd1 = phys_rf[rf_ra1];
    assign rf_rd2 = phys_rf[rf_ra2];
    always @(posedge clk) if (rf_we3) phys_rf[rf_wa3] <= rf_wd3;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural register file plus "cycles since accept"
    int m_rf [8];
    int phase = 0;          // 0 idle, 1..3 = cycles after the accepting edge
    int m_op, m_rd, m_rs1, m_rs2;
    int pend;               // value the current instruction will produce
    int res_m = 0;
    int accepts = 0;
    int done_cnt = 0;
    bit chk_en = 0;

    function automatic int sx8(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    function automatic int alu_model(input int op, input int a, input int b, input int im);
        case (op)
            0: return (a + b) & 255;
            1: return (a - b) & 255;
            2: return a & b;
            3: return a | b;
            4: return (sx8(a) < sx8(b)) ? 1 : 0;
            5: return (a + im) & 255;
            6: return im;
            default: return 0;
        endcase
    endfunction

    // Applied at each rising edge with the inputs that were present before it
    task automatic advance(input logic v, input logic [11:0] ins, input logic [7:0] im, input logic r);
        if (r) begin
            phase = 0;
            res_m = 0;
        end else if (phase == 0) begin
            if (v) begin
                m_op  = int'(ins[11:9]);
                m_rd  = int'(ins[8:6]);
                m_rs1 = int'(ins[5:3]);
                m_rs2 = int'(ins[2:0]);
                pend  = alu_model(m_op, m_rf[m_rs1], m_rf[m_rs2], int'(im));
                phase = 1;
                accepts++;
            end
        end else if (phase == 1) begin
            phase = 2;
        end else if (phase == 2) begin
            phase = 3;
            res_m = pend;
        end else begin
            phase = 0;
            if (m_rd != 0 && m_op != 7) m_rf[m_rd] = pend;
        end
    endtask

    // Single compare process: every cycle, outputs vs model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("instr_ready", 32'(instr_ready), 32'(phase == 0));
            chk("rf_ra1", 32'(rf_ra1), (phase == 1) ? 32'(m_rs1) : 32'd0);
            chk("rf_ra2", 32'(rf_ra2), (phase == 2 - 1) ? 32'(m_rs2) : 32'd0);
            chk("rf_we3", 32'(rf_we3),
                32'(phase == 3 && !rst && m_rd != 0 && m_op != 7));
            chk("done", 32'(done), 32'(phase == 3 && !rst));
            if (!rst) begin
                chk("rf_wa3", 32'(rf_wa3), (phase == 3) ? 32'(m_rd) : 32'd0);
                chk("rf_wd3", 32'(rf_wd3), (phase == 3) ? 32'(pend) : 32'd0);
            end
            chk("result", 32'(result), 32'(res_m));
            if (done) done_cnt++;
        end
    end

    task automatic step(input logic v, input logic [11:0] ins, input logic [7:0] im, input logic r);
        instr_valid = v;
        instr       = ins;
        instr_imm   = im;
        rst         = r;
        @(posedge clk);
        advance(v, ins, im, r);
        #1;
    endtask

    function automatic logic [11:0] mk(input int op, input int rd, input int rs1, input int rs2);
        return {3'(op), 3'(rd), 3'(rs1), 3'(rs2)};
    endfunction

    // Issue from idle and run through WB; ends in the next idle cycle
    task automatic issue(input int op, input int rd, input int rs1, input int rs2, input int im);
        step(1'b1, mk(op, rd, rs1, rs2), 8'(im), 1'b0);
        repeat (3) step(1'b0, 12'h000, 8'h00, 1'b0);
    endtask

    int d0, a0;
    logic [11:0] rnd_ins;

    initial begin
        for (int i = 0; i < 8; i++) m_rf[i] = 0;
        instr_valid = 1'b0; instr = '0; instr_imm = '0; rst = 1'b1;
        repeat (3) step(1'b0, 12'h000, 8'h00, 1'b1);
        chk_en = 1;
        step(1'b0, 12'h000, 8'h00, 1'b0);
        chk("reset ready", 32'(instr_ready), 32'd1);
        chk("reset done", 32'(done), 32'd0);
        chk("reset result", 32'(result), 32'd0);

        // LI r1 = 5
        d0 = done_cnt;
        issue(6, 1, 0, 0, 8'h05);
        chk("LI result", 32'(result), 32'h05);
        chk("LI r1", 32'(phys_rf[1]), 32'h05);
        chk("LI done count", 32'(done_cnt - d0), 32'd1);
        chk("LI ready", 32'(instr_ready), 32'd1);

        issue(6, 2, 0, 0, 8'hFE);
        issue(0, 3, 1, 2, 0);
        chk("ADD wrap", 32'(phys_rf[3]), 32'h03);
        issue(1, 4, 1, 2, 0);
        chk("SUB", 32'(phys_rf[4]), 32'h07);
        issue(4, 5, 1, 2, 0);
        chk("SLT", 32'(result), 32'h00);

        // rd = 0: retires, result updates, no write
        d0 = done_cnt;
        issue(5, 0, 1, 0, 3);
        chk("ADDI rd0 result", 32'(result), 32'h08);
        chk("ADDI rd0 done", 32'(done_cnt - d0), 32'd1);
        issue(0, 7, 0, 0, 0);
        chk("r0 read", 32'(result), 32'h00);

        // valid held 10 cycles with changing instructions
        a0 = accepts; d0 = done_cnt;
        for (int i = 0; i < 10; i++)
            step(1'b1, mk(6, 1 + (i % 7), 0, 0), 8'(i + 8'h40), 1'b0);
        repeat (4) step(1'b0, 12'h000, 8'h00, 1'b0);
        chk("held valid accepts", 32'(accepts - a0), 32'd3);
        chk("held valid dones", 32'(done_cnt - d0), 32'd3);

        // re-establish known values, then reset during WB
        issue(6, 1, 0, 0, 8'h05);
        issue(6, 2, 0, 0, 8'hFE);
        d0 = done_cnt;
        step(1'b1, mk(0, 2, 1, 1), 8'h00, 1'b0);
        step(1'b0, 12'h000, 8'h00, 1'b0);
        step(1'b0, 12'h000, 8'h00, 1'b0);
        step(1'b0, 12'h000, 8'h00, 1'b1);
        chk("rst in WB r2", 32'(phys_rf[2]), 32'hFE);
        chk("rst in WB done", 32'(done_cnt - d0), 32'd0);
        chk("rst in WB ready", 32'(instr_ready), 32'd1);

        // NOP then back-to-back read of the untouched register
        issue(6, 6, 0, 0, 8'h33);
        issue(7, 6, 0, 0, 8'h99);
        chk("NOP result", 32'(result), 32'h00);
        chk("NOP r6", 32'(phys_rf[6]), 32'h33);
        issue(0, 7, 6, 0, 0);
        chk("after NOP", 32'(result), 32'h33);

        // randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            rnd_ins = 12'($urandom);
            step(1'($urandom_range(0, 1)), rnd_ins, 8'($urandom),
                 ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0);
        end
        repeat (4) step(1'b0, 12'h000, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++)
            chk("final regfile", 32'(phys_rf[i]), 32'(m_rf[i]));

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
